// File: rtl/fma16_pkg.sv
// Shared types and constants for the half-precision FMA sequencing controller.
package fma16_pkg;

  typedef enum logic [2:0] {
    FMADD      = 3'd0,
    FMSUB      = 3'd1,
    FNMSUB     = 3'd2,
    FNMADD     = 3'd3,
    FMUL       = 3'd4,
    FADD       = 3'd5,
    FSUB       = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NV = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  localparam logic [15:0] H_ONE       = 16'h3C00;
  localparam logic [15:0] H_NEG_ZERO  = 16'h8000;
  localparam logic [15:0] H_CANON_NAN = 16'h7E00;
  localparam logic [15:0] H_SIGN      = 16'h8000;

  localparam logic [3:0] FLAGS_INVALID = 4'(1 << NV);

endpackage

// File: rtl/fma16_opmap.sv
// Maps an opcode and its A/B/C operands onto the datapath's x*y+z form.
module fma16_opmap
  import fma16_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic [15:0] z_o,
  output logic        illegal_o
);

  op_e op;
  assign op = op_e'(op_i);

  // Negation is a sign-bit flip only so NaN payloads reach the datapath untouched.
  always_comb begin
    x_o       = a_i;
    y_o       = b_i;
    z_o       = c_i;
    illegal_o = 1'b0;
    case (op)
      FMADD:  ;
      FMSUB:  z_o = c_i ^ H_SIGN;
      FNMSUB: x_o = a_i ^ H_SIGN;
      FNMADD: begin
        x_o = a_i ^ H_SIGN;
        z_o = c_i ^ H_SIGN;
      end
      FMUL:   z_o = H_NEG_ZERO;
      FADD: begin
        y_o = H_ONE;
        z_o = b_i;
      end
      FSUB: begin
        y_o = H_ONE;
        z_o = b_i ^ H_SIGN;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fma16_ctrl.sv
// Request/response sequencer that holds FMA operands for a multicycle window,
// captures the result and per-op flags, and accumulates sticky exception flags.
module fma16_ctrl
  import fma16_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int TAGW        = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [15:0]     req_a,
  input  logic [15:0]     req_b,
  input  logic [15:0]     req_c,
  input  logic [TAGW-1:0] req_tag,
  output logic [15:0]     dp_x,
  output logic [15:0]     dp_y,
  output logic [15:0]     dp_z,
  input  logic [15:0]     dp_result,
  input  logic [3:0]      dp_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_result,
  output logic [3:0]      rsp_flags,
  output logic [TAGW-1:0] rsp_tag,
  output logic [3:0]      fflags,
  input  logic            fflags_clr
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     dp_x_q, dp_x_d, dp_y_q, dp_y_d, dp_z_q, dp_z_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [3:0]      fflags_q, fflags_d;

  logic [15:0] map_x, map_y, map_z;
  logic        map_illegal;
  logic        rsp_hs;

  fma16_opmap u_opmap (
    .op_i      (req_op),
    .a_i       (req_a),
    .b_i       (req_b),
    .c_i       (req_c),
    .x_o       (map_x),
    .y_o       (map_y),
    .z_o       (map_z),
    .illegal_o (map_illegal)
  );

  assign rsp_hs = rsp_valid_q & rsp_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dp_x_d       = dp_x_q;
    dp_y_d       = dp_y_q;
    dp_z_d       = dp_z_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    fflags_d     = fflags_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_tag_d = req_tag;
          if (map_illegal) begin
            // Illegal ops bypass the datapath; its operands keep their last values.
            rsp_result_d = H_CANON_NAN;
            rsp_flags_d  = FLAGS_INVALID;
            rsp_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            dp_x_d  = map_x;
            dp_y_d  = map_y;
            dp_z_d  = map_z;
            count_d = CW'(EXEC_CYCLES - 1);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (count_q == '0) begin
          rsp_result_d = dp_result;
          rsp_flags_d  = dp_flags;
          rsp_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a handshake keeps only the retiring op's flags.
    if (rsp_hs) begin
      fflags_d = fflags_clr ? rsp_flags_q : (fflags_q | rsp_flags_q);
    end else if (fflags_clr) begin
      fflags_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      dp_x_q       <= '0;
      dp_y_q       <= '0;
      dp_z_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dp_x_q       <= dp_x_d;
      dp_y_q       <= dp_y_d;
      dp_z_q       <= dp_z_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      fflags_q     <= fflags_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign dp_x       = dp_x_q;
  assign dp_y       = dp_y_q;
  assign dp_z       = dp_z_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;
  assign fflags     = fflags_q;

endmodule

// File: tb/tb_fma16_ctrl.sv
// Directed and randomized bench for fma16_ctrl with a stub datapath and a reference model.
module tb_fma16_ctrl;

  localparam int E    = 2;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = '0;
  logic [15:0]     req_a = '0, req_b = '0, req_c = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic [15:0]     dp_x, dp_y, dp_z;
  logic [15:0]     dp_result;
  logic [3:0]      dp_flags;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [15:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [TAGW-1:0] rsp_tag;
  logic [3:0]      fflags;
  logic            fflags_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [15:0] m_x = '0, m_y = '0, m_z = '0;
  logic [3:0]  m_fflags = '0;

  always #5 clk = ~clk;

  fma16_ctrl #(.EXEC_CYCLES(E), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_tag(req_tag),
    .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .dp_result(dp_result), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  // Stub datapath: true fp16 answers for the directed triples, a scrambling hash otherwise.
  function automatic logic [19:0] dp_stub(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    logic [47:0] k;
    k = {x, y, z};
    case (k)
      48'h3C00_4000_3C00: return {16'h4200, 4'b0000};
      48'h4000_4000_8000: return {16'h4400, 4'b0000};
      48'h3C00_3C00_3C00: return {16'h4000, 4'b0000};
      48'h3C00_3C00_BC00: return {16'h0000, 4'b0000};
      48'h7BFF_4000_0000: return {16'h7C00, 4'b0101};
      48'h3C00_3C00_0000: return {16'h3C00, 4'b0000};
      default: return {x ^ {y[14:0], y[15]} ^ (z + 16'h1234), x[3:0] ^ y[7:4] ^ z[11:8]};
    endcase
  endfunction

  assign {dp_result, dp_flags} = dp_stub(dp_x, dp_y, dp_z);

  // Reference operand mapping: {illegal, x, y, z}
  function automatic logic [48:0] ref_map(input int op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
    logic [15:0] na, nb, nc;
    na = a ^ 16'h8000; nb = b ^ 16'h8000; nc = c ^ 16'h8000;
    case (op)
      0: return {1'b0, a,  b,        c};
      1: return {1'b0, a,  b,        nc};
      2: return {1'b0, na, b,        c};
      3: return {1'b0, na, b,        nc};
      4: return {1'b0, a,  b,        16'h8000};
      5: return {1'b0, a,  16'h3C00, b};
      6: return {1'b0, a,  16'h3C00, nb};
      default: return {1'b1, 48'h0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for response, optional backpressure, handshake.
  task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [TAGW-1:0] tag,
                       input int hold, input bit clr_hs);
    logic [48:0] mp;
    logic [19:0] exp_dp;
    logic [15:0] exp_res;
    logic [3:0]  exp_flg;
    int n;
    mp = ref_map(op, a, b, c);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op[2:0]; req_a = a; req_b = b; req_c = c; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!mp[48]) begin
      m_x = mp[47:32]; m_y = mp[31:16]; m_z = mp[15:0];
    end
    chk("dp_x", dp_x, m_x);
    chk("dp_y", dp_y, m_y);
    chk("dp_z", dp_z, m_z);
    n = 0;
    while (!rsp_valid && n < 50) begin
      chk("req_ready_busy", req_ready, 0);
      @(posedge clk); #1; n++;
    end
    chk("latency", n, mp[48] ? 0 : E);
    exp_dp  = dp_stub(m_x, m_y, m_z);
    exp_res = mp[48] ? 16'h7E00 : exp_dp[19:4];
    exp_flg = mp[48] ? 4'b1000 : exp_dp[3:0];
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_flags", rsp_flags, exp_flg);
    chk("rsp_tag", rsp_tag, tag);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 3'd0; req_a = $urandom; req_b = $urandom; req_c = $urandom;
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, exp_res);
      chk("bp_flags", rsp_flags, exp_flg);
      chk("bp_tag", rsp_tag, tag);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_dp_x", dp_x, m_x);
      chk("bp_fflags", fflags, m_fflags);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1; fflags_clr = clr_hs;
    @(posedge clk); #1;
    rsp_ready = 1'b0; fflags_clr = 1'b0;
    m_fflags = clr_hs ? exp_flg : (m_fflags | exp_flg);
    chk("hs_valid_drop", rsp_valid, 0);
    chk("hs_req_ready", req_ready, 1);
    chk("fflags", fflags, m_fflags);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_dp", {dp_x, dp_y}, 0);
    chk("rst_dp_z", dp_z, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed functional cases
    do_op(0, 16'h3C00, 16'h4000, 16'h3C00, 4'hA, 0, 1'b0);
    chk("fmadd_result", rsp_result, 16'h4200);
    do_op(4, 16'h4000, 16'h4000, 16'h1234, 4'h3, 0, 1'b0);
    chk("fmul_result", rsp_result, 16'h4400);
    do_op(5, 16'h3C00, 16'h3C00, 16'h0000, 4'h5, 0, 1'b0);
    chk("fadd_result", rsp_result, 16'h4000);
    do_op(6, 16'h3C00, 16'h3C00, 16'h0000, 4'h6, 0, 1'b0);
    chk("fsub_result", rsp_result, 16'h0000);
    do_op(7, 16'h1111, 16'h2222, 16'h3333, 4'hF, 0, 1'b0);
    chk("illegal_fflags", fflags, 4'b1000);
    do_op(1, 16'h4000, 16'h3C00, 16'h3800, 4'h9, 5, 1'b0);

    // Sticky flags
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    m_fflags = '0;
    chk("clr_alone", fflags, 0);
    do_op(0, 16'h7BFF, 16'h4000, 16'h0000, 4'h1, 0, 1'b0);
    chk("sticky_of", fflags, 4'b0101);
    do_op(0, 16'h3C00, 16'h3C00, 16'h0000, 4'h2, 1, 1'b0);
    chk("sticky_keep", fflags, 4'b0101);
    do_op(0, 16'h3C00, 16'h3C00, 16'h0000, 4'h4, 0, 1'b1);
    chk("sticky_clr_hs", fflags, 4'b0000);

    // Reset in the middle of an operation
    req_valid = 1'b1; req_op = 3'd2; req_a = 16'h4400; req_b = 16'h4000; req_c = 16'h3C00;
    req_tag = 4'hC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_dp_x", dp_x, 0);
    chk("mid_rst_rsp_tag", rsp_tag, 0);
    chk("mid_rst_fflags", fflags, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_x = '0; m_y = '0; m_z = '0; m_fflags = '0;
    for (int i = 0; i < E + 3; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    do_op(2, 16'h4400, 16'h4000, 16'h3C00, 4'hD, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        m_fflags = '0;
        chk("rand_clr", fflags, 0);
      end
      do_op(int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
            TAGW'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fma16_ctrl.md
Name: fma16_ctrl

Overview:
Sequencing and configuration controller for the half-precision fused multiply-add datapath, which contains the special-case and flag logic.
- Accepts one operation at a time over a valid/ready request channel.
- Maps the opcode onto the datapath's x*y+z operand form.
- Holds the operands stable for a configurable multicycle window, then captures the result and per-op flags.
- Returns the result over a valid/ready response channel and accumulates sticky exception flags (fflags).

Parameters:
- EXEC_CYCLES, 2: cycles the datapath operands are held before the result is sampled; must be >= 1.
- TAGW, 4: width of the request/response tag.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_op  in  3  opcode (see Behaviour)
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_c  in  16  operand C
- req_tag  in  TAGW  request tag, returned unchanged
- dp_x  out  16  datapath x operand
- dp_y  out  16  datapath y operand
- dp_z  out  16  datapath z operand
- dp_result  in  16  datapath result (combinational from dp_x/y/z)
- dp_flags  in  4  datapath flags {NV,OF,UF,NX}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_result  out  16  result
- rsp_flags  out  4  per-op flags {NV,OF,UF,NX}
- rsp_tag  out  TAGW  tag of the op
- fflags  out  4  sticky accumulated flags
- fflags_clr  in  1  synchronous clear of fflags

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, fflags=0, dp_x=dp_y=dp_z=0, count=0.
- Reset mid-operation discards the in-flight op; no response is produced.
- FSM IDLE -> EXEC -> DONE.
- req_ready = (state==IDLE). The request is accepted on req_valid & req_ready.
- Opcode mapping, registered into dp_x/dp_y/dp_z at acceptance:
  - 0 FMADD: A, B, C
  - 1 FMSUB: A, B, C^0x8000
  - 2 FNMSUB: A^0x8000, B, C
  - 3 FNMADD: A^0x8000, B, C^0x8000
  - 4 FMUL: A, B, 0x8000 (-0, so the product's sign is preserved exactly)
  - 5 FADD: A, 0x3C00, B
  - 6 FSUB: A, 0x3C00, B^0x8000
  - 7: illegal
- Negation is a sign-bit flip only; NaN payloads pass through and the datapath canonicalises them.
- Legal op: IDLE -> EXEC and count <= EXEC_CYCLES-1.
  - In EXEC, count decrements each cycle.
  - When count==0: rsp_result <= dp_result, rsp_flags <= dp_flags, rsp_valid <= 1, go to DONE.
- Illegal op: IDLE -> DONE directly.
  - rsp_result = 0x7E00, rsp_flags = 4'b1000.
  - dp_x/dp_y/dp_z are left unchanged.
- Latency from acceptance at cycle T: rsp_valid rises at T+1+EXEC_CYCLES for a legal op, T+1 for an illegal op.
- dp_x/dp_y/dp_z remain stable from T+1 until the next acceptance.
- DONE: rsp_* are held stable while rsp_valid & ~rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - A new request is accepted no earlier than the cycle after that handshake.
- fflags update on the response handshake: fflags <= fflags | rsp_flags.
- fflags_clr alone: fflags <= 0.
- fflags_clr in the same cycle as a handshake: fflags <= rsp_flags.
- rsp_tag is captured at acceptance.

Decomposition:
- Package fma16_pkg holds:
  - op enum (FMADD..FSUB, OP_ILLEGAL=7)
  - flag bit indices NV=3, OF=2, UF=1, NX=0
  - constants H_ONE=16'h3C00, H_NEG_ZERO=16'h8000, H_CANON_NAN=16'h7E00, H_SIGN=16'h8000
  - state enum {IDLE, EXEC, DONE}
- Sub-module fma16_opmap: combinational op + A/B/C -> x/y/z plus illegal flag. The controller instantiates it and registers its outputs.

Test Plan:
- FMADD A=0x3C00, B=0x4000, C=0x3C00 with the reference fma16 attached, EXEC_CYCLES=2: rsp_result=0x4200, flags 0, rsp_valid at T+3, tag echoed.
- FMUL A=0x4000, B=0x4000: dp_z=0x8000, result 0x4400. FADD A=0x3C00, B=0x3C00: dp_y=0x3C00, dp_z=0x3C00, result 0x4000. FSUB same operands: result 0x0000.
- Op 7: rsp_valid at T+1, result 0x7E00, flags 4'b1000; dp_* unchanged; fflags becomes 4'b1000 after handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE; rsp_* stable, req_ready=0, a second req_valid is not accepted until the cycle after the handshake.
- Sticky flags: FMADD 0x7BFF*0x4000+0x0000 gives flags 4'b0101, fflags=0101. Then the exact op 1.0*1.0+0 leaves fflags at 0101. fflags_clr asserted with the next handshake (flags 0) gives 0000.
- Assert reset_n low during EXEC: all outputs return to reset values immediately, no response emitted, next request is serviced normally.
